// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding and default widths shared by the ALU execute stage
package alu_pkg;

    localparam int ALU_DATA_W = 64;
    localparam int ALU_TAG_W  = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: operation-in / result-out handshake bundle of the execute stage
interface alu_exec_stage_if #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
);

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_flag;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_flag, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_flag, out_tag
    );

endinterface

// File: rtl/alu.sv
// alu: combinational add/sub/and/xor with carry (add) or borrow (sub) flag
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              flag
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // the extra top bit is carry-out for add and borrow (a < b) for sub
    always_comb begin
        result = (op == OP_ADD) ? sum[DATA_W-1:0] :
                 (op == OP_SUB) ? diff[DATA_W-1:0] :
                 (op == OP_AND) ? (a & b) : (a ^ b);
        flag   = (op == OP_ADD) ? sum[DATA_W] :
                 (op == OP_SUB) ? diff[DATA_W] : 1'b0;
    end

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: operand register -> alu -> 2-entry result FIFO, with sticky flag and retire counter
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int TAG_W  = ALU_TAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_exec_stage_if.slave   bus,
    input  logic              flag_clr,
    output logic              flag_sticky,
    output logic [15:0]       retired_cnt,
    output logic              busy
);

    logic              op_valid;
    alu_op_e           op_op;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [TAG_W-1:0]  op_tag;

    logic [DATA_W-1:0] alu_result;
    logic              alu_flag;

    logic [DATA_W-1:0] buf_result [2];
    logic              buf_flag   [2];
    logic [TAG_W-1:0]  buf_tag    [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    logic              accept;
    logic              advance;
    logic              retire;

    // a retire frees a buffer slot on the same edge, so a full buffer still lets the operand advance
    assign retire         = bus.out_valid && bus.out_ready;
    assign advance        = op_valid && (count != 2'd2 || retire);
    assign bus.in_ready   = !op_valid || advance;
    assign accept         = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = count != 2'd0;
    assign bus.out_result = bus.out_valid ? buf_result[rd_ptr] : '0;
    assign bus.out_flag   = bus.out_valid && buf_flag[rd_ptr];
    assign bus.out_tag    = bus.out_valid ? buf_tag[rd_ptr] : '0;
    assign busy           = op_valid || bus.out_valid;

    alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op_op),
        .a      (op_a),
        .b      (op_b),
        .result (alu_result),
        .flag   (alu_flag)
    );

    // control state: operand valid, FIFO pointers/count, sticky flag, retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid    <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            flag_sticky <= 1'b0;
            retired_cnt <= 16'd0;
        end else begin
            if (bus.in_ready)
                op_valid <= bus.in_valid;
            wr_ptr      <= wr_ptr ^ advance;
            rd_ptr      <= rd_ptr ^ retire;
            count       <= count + {1'b0, advance} - {1'b0, retire};
            flag_sticky <= (retire && bus.out_flag) ? 1'b1 : flag_clr ? 1'b0 : flag_sticky;
            retired_cnt <= retired_cnt + {15'd0, retire};
        end
    end

    // datapath storage needs no reset: outputs are gated by out_valid and alu inputs by op_valid
    always_ff @(posedge clk) begin
        if (accept) begin
            op_op  <= alu_op_e'(bus.in_op);
            op_a   <= bus.in_a;
            op_b   <= bus.in_b;
            op_tag <= bus.in_tag;
        end
        if (advance) begin
            buf_result[wr_ptr] <= alu_result;
            buf_flag[wr_ptr]   <= alu_flag;
            buf_tag[wr_ptr]    <= op_tag;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed and random checks of the ALU execute stage against an in-order result model
module tb_alu_exec_stage;

    typedef struct {
        logic [63:0] r;
        logic        f;
        logic [3:0]  t;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flag_clr;
    logic        flag_sticky;
    logic [15:0] retired_cnt;
    logic        busy;

    alu_exec_stage_if #(.DATA_W(64), .TAG_W(4)) bus ();

    alu_exec_stage #(.DATA_W(64), .TAG_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .flag_clr    (flag_clr),
        .flag_sticky (flag_sticky),
        .retired_cnt (retired_cnt),
        .busy        (busy)
    );

    int     n_cmp = 0;
    int     n_bad = 0;
    exp_t   q[$];
    int     occ = 0;
    logic   sticky_m = 1'b0;
    logic [15:0] cnt_m = 16'd0;
    logic   acc;
    logic   ret;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                    input logic [3:0] t);
        exp_t e;
        e.t = t;
        e.f = 1'b0;
        case (op)
            2'd0: begin e.r = a + b; e.f = (e.r < a); end
            2'd1: begin e.r = a - b; e.f = (a < b); end
            2'd2: e.r = a & b;
            default: e.r = a ^ b;
        endcase
        return e;
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 3))
            0: return 64'hFFFF_FFFF_FFFF_FFFF;
            1: return 64'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic rnd_op(input logic [3:0] t);
        bus.in_op  = 2'($urandom_range(0, 3));
        bus.in_a   = rnd64();
        bus.in_b   = rnd64();
        bus.in_tag = t;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic [3:0] t);
        bus.in_op  = op;
        bus.in_a   = a;
        bus.in_b   = b;
        bus.in_tag = t;
    endtask

    // one clock: sample handshakes at negedge, check outputs against the oldest outstanding result
    task automatic cycle();
        logic ret_flag;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        ret = bus.out_valid && bus.out_ready;
        ret_flag = 1'b0;
        check("busy", 64'(busy), 64'(occ != 0));
        if (occ == 0)
            check("rdy_idle", 64'(bus.in_ready), 64'd1);
        if (occ == 3 && !bus.out_ready)
            check("rdy_full", 64'(bus.in_ready), 64'd0);
        if (bus.out_valid) begin
            if (q.size() == 0)
                check("spurious", 64'(bus.out_valid), 64'd0);
            else begin
                check("result", bus.out_result, q[0].r);
                check("flag", 64'(bus.out_flag), 64'(q[0].f));
                check("tag", 64'(bus.out_tag), 64'(q[0].t));
                ret_flag = ret && q[0].f;
            end
        end
        if (ret && q.size() != 0)
            void'(q.pop_front());
        if (acc)
            q.push_back(ref_op(bus.in_op, bus.in_a, bus.in_b, bus.in_tag));
        occ = occ + int'(acc) - int'(ret);
        sticky_m = ret_flag ? 1'b1 : flag_clr ? 1'b0 : sticky_m;
        if (ret)
            cnt_m = cnt_m + 16'd1;
        @(posedge clk);
        #1;
        check("sticky", 64'(flag_sticky), 64'(sticky_m));
        check("retired", 64'(retired_cnt), 64'(cnt_m));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ov"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_ir"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_res"}, bus.out_result, 64'd0);
        check({tag, "_flg"}, 64'(bus.out_flag), 64'd0);
        check({tag, "_tag"}, 64'(bus.out_tag), 64'd0);
        check({tag, "_stk"}, 64'(flag_sticky), 64'd0);
        check({tag, "_cnt"}, 64'(retired_cnt), 64'd0);
    endtask

    initial begin
        int n_acc;
        int n_ret;
        rst_n        = 1'b0;
        flag_clr     = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_op(2'd0, 64'd0, 64'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // carry-out of all-ones plus one, two-cycle latency
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        set_op(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd3);
        cycle();
        bus.in_valid = 1'b0;
        check("lat_early", 64'(bus.out_valid), 64'd0);
        cycle();
        check("lat_ov", 64'(bus.out_valid), 64'd1);
        check("carry_res", bus.out_result, 64'd0);
        check("carry_flg", 64'(bus.out_flag), 64'd1);
        check("carry_tag", 64'(bus.out_tag), 64'd3);
        cycle();
        check("carry_stk", 64'(flag_sticky), 64'd1);

        // back-to-back subtracts retire on consecutive cycles
        bus.in_valid = 1'b1;
        set_op(2'd1, 64'd5, 64'd3, 4'd1);
        cycle();
        set_op(2'd1, 64'd3, 64'd5, 4'd2);
        cycle();
        bus.in_valid = 1'b0;
        check("sub1_ov", 64'(bus.out_valid), 64'd1);
        check("sub1_res", bus.out_result, 64'd2);
        check("sub1_flg", 64'(bus.out_flag), 64'd0);
        cycle();
        check("sub2_ov", 64'(bus.out_valid), 64'd1);
        check("sub2_res", bus.out_result, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub2_flg", 64'(bus.out_flag), 64'd1);
        cycle();

        // backpressure: only three ops fit, then drain in order
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            rnd_op(4'(i + 4));
            cycle();
            n_acc += int'(acc);
        end
        check("bp_acc", 64'(n_acc), 64'd3);
        check("bp_ir", 64'(bus.in_ready), 64'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) cycle();
        check("bp_occ", 64'(occ), 64'd0);

        // logical ops clear the flag
        bus.in_valid = 1'b1;
        set_op(2'd2, 64'hF0F0, 64'hFF00, 4'd5);
        cycle();
        set_op(2'd3, 64'hF0F0, 64'hFF00, 4'd6);
        cycle();
        bus.in_valid = 1'b0;
        check("and_res", bus.out_result, 64'hF000);
        check("and_flg", 64'(bus.out_flag), 64'd0);
        cycle();
        check("xor_res", bus.out_result, 64'h0FF0);
        check("xor_flg", 64'(bus.out_flag), 64'd0);
        cycle();

        // clear, then a clear coinciding with a flag-1 retire leaves sticky set
        flag_clr = 1'b1;
        cycle();
        flag_clr = 1'b0;
        check("clr_stk", 64'(flag_sticky), 64'd0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        set_op(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd7);
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        flag_clr      = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        flag_clr = 1'b0;
        check("setwins_stk", 64'(flag_sticky), 64'd1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 4) < 3);
            flag_clr      = ($urandom_range(0, 9) == 0);
            rnd_op(4'($urandom));
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        flag_clr      = 1'b0;
        for (int i = 0; i < 10 && occ != 0; i++)
            cycle();
        check("drain_occ", 64'(occ), 64'd0);

        // reset with the stage full discards everything
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rnd_op(4'(i + 8));
            cycle();
        end
        check("full_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid");
        q.delete();
        occ      = 0;
        sticky_m = 1'b0;
        cnt_m    = 16'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (5) cycle();
        check("post_rst_ov", 64'(bus.out_valid), 64'd0);

        // 65536 retires wrap the counter to zero
        n_acc = 0;
        n_ret = 0;
        for (int i = 0; i < 70000 && n_ret < 65536; i++) begin
            bus.in_valid = (n_acc < 65536);
            rnd_op(4'($urandom));
            cycle();
            n_acc += int'(acc);
            n_ret += int'(ret);
        end
        check("wrap_n", 64'(n_ret), 64'd65536);
        check("wrap_cnt", 64'(retired_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
